top_if: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS: program counter, program memory and IF/ID pipeline register.

---
 rtl/top_if_pkg.sv | 18 +
 rtl/top_if_program_memory.sv | 27 ++
 rtl/top_if.sv | 158 +++++++++++++++
 tb/tb_top_if.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/top_if_pkg.sv
// Shared definitions for the instruction-fetch stage: controller states
// and the special instruction encodings used for halting and bubbles.
package top_if_pkg;

    // Controller states: program load, free-running fetch, stopped on HALT.
    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } if_state_e;

    // Word that stops fetch when it reaches the PC.
    localparam logic [31:0] IF_HALT_WORD = 32'hFFFF_FFFF;

    // Bubble placed in IF/ID on flush and whenever the stage is not fetching.
    localparam logic [31:0] IF_NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/top_if_program_memory.sv
// Program memory for the fetch stage: one write port used by the debug
// unit while loading, and a combinational read port addressed by the PC.
module program_memory #(
    parameter int LENGTH_INSTRUCTION = 32,
    parameter int CANT_BITS_ADDR     = 11,
    parameter int RAM_DEPTH          = 2**CANT_BITS_ADDR
) (
    input  logic                          i_clock,
    input  logic                          i_wr_enable,
    input  logic [CANT_BITS_ADDR-1:0]     i_wr_addr,
    input  logic [LENGTH_INSTRUCTION-1:0] i_wr_data,
    input  logic [CANT_BITS_ADDR-1:0]     i_rd_addr,
    output logic [LENGTH_INSTRUCTION-1:0] o_rd_data
);

    logic [LENGTH_INSTRUCTION-1:0] mem [RAM_DEPTH];

    // Contents are never cleared so a program survives a reset.
    always_ff @(posedge i_clock) begin
        if (i_wr_enable) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/top_if.sv
// Instruction-fetch stage: PC, program memory, IF/ID register, run-cycle
// counter and the LOAD/RUN/HALT controller driven by the debug unit.
module top_if
    import top_if_pkg::*;
#(
    parameter int                            LENGTH_INSTRUCTION = 32,
    parameter int                            CANT_BITS_ADDR     = 11,
    parameter int                            RAM_DEPTH          = 2**CANT_BITS_ADDR,
    parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION   = IF_HALT_WORD,
    parameter logic [LENGTH_INSTRUCTION-1:0] NOP_INSTRUCTION    = IF_NOP_WORD,
    parameter int                            CANT_BITS_CYCLES   = 32
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_enable_pipeline,
    input  logic                          i_enable_etapa,
    input  logic                          i_stall,
    input  logic                          i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
    input  logic                          i_start,
    input  logic                          i_reload,
    input  logic                          i_wr_program_enable,
    input  logic [CANT_BITS_ADDR-1:0]     i_wr_program_addr,
    input  logic [LENGTH_INSTRUCTION-1:0] i_wr_program_data,
    output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
    output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
    output logic [CANT_BITS_ADDR-1:0]     o_pc,
    output logic                          o_halt,
    output logic [CANT_BITS_CYCLES-1:0]   o_cycle_count
);

    if_state_e                     state_q;
    if_state_e                     state_d;
    logic [CANT_BITS_ADDR-1:0]     pc_p0;
    logic [CANT_BITS_ADDR-1:0]     pc_d;
    logic [CANT_BITS_ADDR-1:0]     pc_plus1;
    logic [LENGTH_INSTRUCTION-1:0] instr_p1;
    logic [LENGTH_INSTRUCTION-1:0] instr_d;
    logic [CANT_BITS_ADDR-1:0]     npc_p1;
    logic [CANT_BITS_ADDR-1:0]     npc_d;
    logic [CANT_BITS_CYCLES-1:0]   cnt_q;
    logic [CANT_BITS_CYCLES-1:0]   cnt_d;
    logic [LENGTH_INSTRUCTION-1:0] fetched;
    logic                          mem_we;
    logic                          adv;

    // The debug unit may only rewrite the program while nothing is fetching.
    assign mem_we = (state_q == ST_LOAD) & i_wr_program_enable;

    program_memory #(
        .LENGTH_INSTRUCTION (LENGTH_INSTRUCTION),
        .CANT_BITS_ADDR     (CANT_BITS_ADDR),
        .RAM_DEPTH          (RAM_DEPTH)
    ) u_program_memory (
        .i_clock     (i_clock),
        .i_wr_enable (mem_we),
        .i_wr_addr   (i_wr_program_addr),
        .i_wr_data   (i_wr_program_data),
        .i_rd_addr   (pc_p0),
        .o_rd_data   (fetched)
    );

    // A fetch slot is consumed only when running, globally enabled, stage
    // enabled and decode is not holding us for a load-use hazard.
    assign adv      = (state_q == ST_RUN) & i_enable_pipeline & i_enable_etapa & ~i_stall;
    assign pc_plus1 = pc_p0 + CANT_BITS_ADDR'(1);

    // Next-state, next-PC and IF/ID selection; everything holds by default.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_p0;
        instr_d = instr_p1;
        npc_d   = npc_p1;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOAD: begin
                pc_d    = '0;
                instr_d = NOP_INSTRUCTION;
                npc_d   = '0;
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (adv) begin
                    cnt_d = cnt_q + CANT_BITS_CYCLES'(1);
                    if (i_branch_control) begin
                        // Redirect wins over everything, including a HALT
                        // word fetched on the wrong path.
                        pc_d    = i_branch_dir;
                        instr_d = NOP_INSTRUCTION;
                        npc_d   = '0;
                    end else if (fetched == HALT_INSTRUCTION) begin
                        // Pass HALT down the pipe once and park the PC on it.
                        instr_d = HALT_INSTRUCTION;
                        npc_d   = pc_plus1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_plus1;
                        instr_d = fetched;
                        npc_d   = pc_plus1;
                    end
                end else if (i_enable_pipeline && !i_enable_etapa) begin
                    instr_d = NOP_INSTRUCTION;
                    npc_d   = '0;
                end
            end
            ST_HALT: begin
                if (i_enable_pipeline) begin
                    instr_d = NOP_INSTRUCTION;
                    npc_d   = '0;
                end
                if (i_reload) begin
                    state_d = ST_LOAD;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_LOAD;
                pc_d    = '0;
                instr_d = NOP_INSTRUCTION;
                npc_d   = '0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, IF/ID register and run-cycle counter.
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            pc_p0    <= '0;
            instr_p1 <= NOP_INSTRUCTION;
            npc_p1   <= '0;
            cnt_q    <= '0;
        end else begin
            pc_p0    <= pc_d;
            instr_p1 <= instr_d;
            npc_p1   <= npc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_instruction  = instr_p1;
    assign o_out_adder_pc = npc_p1;
    assign o_pc           = pc_p0;
    assign o_halt         = (state_q == ST_HALT);
    assign o_cycle_count  = cnt_q;

endmodule

// File: tb/tb_top_if.sv
// Directed bench for top_if: a mode-level reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_top_if;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_W  = 32'h0000_0000;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk;
    logic        rst_n;
    logic        en_pipe;
    logic        en_etapa;
    logic        stall;
    logic        branch;
    logic [10:0] branch_dir;
    logic        start;
    logic        reload;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] instruction;
    logic [10:0] out_adder_pc;
    logic [10:0] pc;
    logic        halt;
    logic [31:0] cycle_count;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    top_if dut (
        .i_clock             (clk),
        .i_soft_reset        (rst_n),
        .i_enable_pipeline   (en_pipe),
        .i_enable_etapa      (en_etapa),
        .i_stall             (stall),
        .i_branch_control    (branch),
        .i_branch_dir        (branch_dir),
        .i_start             (start),
        .i_reload            (reload),
        .i_wr_program_enable (wr_en),
        .i_wr_program_addr   (wr_addr),
        .i_wr_program_data   (wr_data),
        .o_instruction       (instruction),
        .o_out_adder_pc      (out_adder_pc),
        .o_pc                (pc),
        .o_halt              (halt),
        .o_cycle_count       (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the fetch stage must present after each edge.
    int          m_mode;
    logic [31:0] m_mem [2048];
    logic [10:0] m_pc;
    logic [31:0] m_instr;
    logic [10:0] m_npc;
    logic [31:0] m_cnt;

    initial begin
        for (int i = 0; i < 2048; i++) m_mem[i] = 32'h0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_LOAD; m_pc = 11'd0; m_instr = NOP_W; m_npc = 11'd0; m_cnt = 32'd0;
        end else begin
            if (m_mode == M_LOAD) begin
                if (wr_en) m_mem[wr_addr] = wr_data;
                m_pc = 11'd0; m_instr = NOP_W; m_npc = 11'd0;
                if (start) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (en_pipe && !en_etapa) begin
                    m_instr = NOP_W; m_npc = 11'd0;
                end else if (en_pipe && !stall) begin
                    m_cnt = m_cnt + 32'd1;
                    if (branch) begin
                        m_pc = branch_dir; m_instr = NOP_W; m_npc = 11'd0;
                    end else if (m_mem[m_pc] == HALT_W) begin
                        m_instr = HALT_W; m_npc = m_pc + 11'd1; m_mode = M_HALT;
                    end else begin
                        m_instr = m_mem[m_pc]; m_npc = m_pc + 11'd1; m_pc = m_pc + 11'd1;
                    end
                end
            end else begin
                if (en_pipe) begin
                    m_instr = NOP_W; m_npc = 11'd0;
                end
                if (reload) begin
                    m_mode = M_LOAD; m_pc = 11'd0; m_cnt = 32'd0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_instr", instruction, m_instr);
            chk("model_npc", {21'd0, out_adder_pc}, {21'd0, m_npc});
            chk("model_pc", {21'd0, pc}, {21'd0, m_pc});
            chk("model_halt", {31'd0, halt}, {31'd0, (m_mode == M_HALT)});
            chk("model_cnt", cycle_count, m_cnt);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1; tick(); reload = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] ins, input logic [10:0] npc_v,
                             input logic [10:0] pc_v);
        chk({name, "_instr"}, instruction, ins);
        chk({name, "_npc"}, {21'd0, out_adder_pc}, {21'd0, npc_v});
        chk({name, "_pc"}, {21'd0, pc}, {21'd0, pc_v});
    endtask

    initial begin
        rst_n = 1'b0; en_pipe = 1'b1; en_etapa = 1'b1; stall = 1'b0; branch = 1'b0;
        branch_dir = 11'd0; start = 1'b0; reload = 1'b0; wr_en = 1'b0; wr_addr = 11'd0;
        wr_data = 32'd0;
        tick(2);
        check_en = 1'b1;
        fetch_chk("reset", NOP_W, 11'd0, 11'd0);
        chk("reset_halt", {31'd0, halt}, 32'd0);
        chk("reset_cnt", cycle_count, 32'd0);
        rst_n = 1'b1;

        // Program A: two instructions then HALT.
        wr(11'd0, 32'h2001_0005);
        wr(11'd1, 32'h2002_0003);
        wr(11'd2, HALT_W);
        pulse_start();
        chk("a_started_nop", instruction, NOP_W);
        tick(); fetch_chk("a_f0", 32'h2001_0005, 11'd1, 11'd1);
        tick(); fetch_chk("a_f1", 32'h2002_0003, 11'd2, 11'd2);
        tick(); fetch_chk("a_halt", HALT_W, 11'd3, 11'd2);
        chk("a_halt_flag", {31'd0, halt}, 32'd1);
        tick(); chk("a_after_halt", instruction, NOP_W);
        chk("a_cnt", cycle_count, 32'd3);
        pulse_start();
        chk("a_start_ignored", {31'd0, halt}, 32'd1);
        pulse_reload();
        chk("a_reload_halt", {31'd0, halt}, 32'd0);
        chk("a_reload_cnt", cycle_count, 32'd0);

        // Program B: branches, stalls, wrap-around, wrong-path HALT.
        wr(11'd0, 32'h0000_0011); wr(11'd1, 32'h0000_0022); wr(11'd2, 32'h0000_0033);
        wr(11'd3, 32'h0000_0044); wr(11'd4, 32'h0000_0055); wr(11'd5, 32'h0000_0066);
        wr(11'h040, 32'hAAAA_0040); wr(11'h041, 32'hAAAA_0041); wr(11'h042, HALT_W);
        // Last write shares its edge with the start request.
        start = 1'b1; wr(11'h7FF, 32'h7FF7_FF7F); start = 1'b0;
        tick(3); fetch_chk("b_f2", 32'h0000_0033, 11'd3, 11'd3);
        stall = 1'b1; branch = 1'b1; branch_dir = 11'h100;
        tick(2);
        fetch_chk("b_stall", 32'h0000_0033, 11'd3, 11'd3);
        chk("b_stall_cnt", cycle_count, 32'd3);
        stall = 1'b0; branch = 1'b0;
        tick(2); fetch_chk("b_f4", 32'h0000_0055, 11'd5, 11'd5);
        branch = 1'b1; branch_dir = 11'h040;
        tick(); branch = 1'b0;
        fetch_chk("b_flush", NOP_W, 11'd0, 11'h040);
        tick(); fetch_chk("b_target", 32'hAAAA_0040, 11'h041, 11'h041);
        wr(11'h041, 32'hDEAD_BEEF);
        fetch_chk("b_run_write", 32'hAAAA_0041, 11'h042, 11'h042);
        branch = 1'b1; branch_dir = 11'h7FF;
        tick(); branch = 1'b0;
        fetch_chk("b_wrong_path_halt", NOP_W, 11'd0, 11'h7FF);
        chk("b_no_halt", {31'd0, halt}, 32'd0);
        tick(); fetch_chk("b_wrap", 32'h7FF7_FF7F, 11'h000, 11'h000);
        tick(); fetch_chk("b_after_wrap", 32'h0000_0011, 11'd1, 11'd1);
        en_etapa = 1'b0;
        tick(); fetch_chk("b_etapa_off", NOP_W, 11'd0, 11'd1);
        chk("b_etapa_cnt", cycle_count, 32'd11);
        en_etapa = 1'b1; en_pipe = 1'b0;
        tick(); fetch_chk("b_pipe_off", NOP_W, 11'd0, 11'd1);
        en_pipe = 1'b1;
        branch = 1'b1; branch_dir = 11'h042;
        tick(); branch = 1'b0;
        tick(); fetch_chk("b_halt", HALT_W, 11'h043, 11'h042);
        tick(); chk("b_halt_once", instruction, NOP_W);
        pulse_reload();

        // Asynchronous reset between edges, then prove memory survived.
        pulse_start();
        tick(2); fetch_chk("r_pre", 32'h0000_0022, 11'd2, 11'd2);
        #1 rst_n = 1'b0;
        #1;
        fetch_chk("r_async", NOP_W, 11'd0, 11'd0);
        chk("r_async_cnt", cycle_count, 32'd0);
        tick(2);
        rst_n = 1'b1;
        pulse_start();
        tick(); fetch_chk("r_mem0", 32'h0000_0011, 11'd1, 11'd1);
        branch = 1'b1; branch_dir = 11'h041;
        tick(); branch = 1'b0;
        tick(); fetch_chk("r_mem41", 32'hAAAA_0041, 11'h042, 11'h042);
        tick();
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
